// File: rtl/fir_lowpass_16tap.sv
// ----------------------------------------------------------------------------
// fir_lowpass_16tap
//   16-tap symmetric low-pass FIR for 16-bit signed samples. The filter takes
//   one sample per clock, has no handshake and a fixed 4-clock latency.
//   The structure is fully pipelined:
//     delay line -> symmetric pre-add -> multiply -> adder tree -> round/clip
//   Coefficients are fixed Q1.15 values. Their sum is 32768, so the DC gain
//   is exactly 1.0.
//
//   Build option:
//     FIR_SAT_EN  defined   : the output saturates to [-32768, 32767]
//                 undefined : the output wraps (keeps the low 16 bits of the
//                             rounded result); rounding is identical
// ----------------------------------------------------------------------------
module fir_lowpass_16tap #(
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int NTAPS  = 16,
   parameter int ACC_W  = 36
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic signed [DATA_W-1:0] data_in,
   output logic signed [DATA_W-1:0] data_out
);

   localparam int HALF   = NTAPS / 2;
   localparam int PRE_W  = DATA_W + 1;        // pre-add of two samples
   localparam int PROD_W = PRE_W + COEF_W;    // signed product width
   localparam int FRAC_W = COEF_W - 1;        // Q1.15 fraction bits

   // +0.5 LSB of the output; adding it before the shift gives round-half-up.
   localparam logic signed [ACC_W-1:0] ROUND_HALF =
      {{(ACC_W-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};

   typedef logic signed [DATA_W-1:0] sample_t;
   typedef logic signed [COEF_W-1:0] coef_t;
   typedef logic signed [PRE_W-1:0]  pre_t;
   typedef logic signed [PROD_W-1:0] prod_t;
   typedef logic signed [ACC_W-1:0]  acc_t;

   // One half of the symmetric impulse response; h[NTAPS-1-i] == h[i].
   function automatic coef_t coef(input int idx);
      case (idx)
         0:       return -16'sd92;
         1:       return -16'sd210;
         2:       return -16'sd180;
         3:       return  16'sd360;
         4:       return  16'sd1480;
         5:       return  16'sd3400;
         6:       return  16'sd5200;
         7:       return  16'sd6426;
         default: return  16'sd0;
      endcase
   endfunction

   // ------------------------------------------------------------------------
   // Pipeline state
   // ------------------------------------------------------------------------
   sample_t x_q [NTAPS];
   sample_t x_d [NTAPS];
   pre_t    p_q [HALF];
   pre_t    p_d [HALF];
   prod_t   m_q [HALF];
   prod_t   m_d [HALF];
   acc_t    s_q;
   acc_t    s_d;
   sample_t y_q;
   sample_t y_d;

   acc_t    rounded;
   acc_t    r;

   // Stage 0: shift the new sample into the tapped delay line.
   // NOTE: every always_comb assigns all of its outputs unconditionally
   // before any branch, so no path can leave a value held (no latch).
   always_comb begin
      x_d[0] = data_in;
      for (int i = 1; i < NTAPS; i++) begin
         x_d[i] = x_q[i-1];
      end
   end

   // Stage 1: fold the symmetric taps. The add is one bit wider than a
   // sample, so -32768 + -32768 is representable and cannot wrap.
   always_comb begin
      for (int i = 0; i < HALF; i++) begin
         p_d[i] = $signed({x_q[i][DATA_W-1], x_q[i]})
                + $signed({x_q[NTAPS-1-i][DATA_W-1], x_q[NTAPS-1-i]});
      end
   end

   // Stage 2: scale each folded pair by its coefficient (signed x signed).
   always_comb begin
      for (int i = 0; i < HALF; i++) begin
         m_d[i] = PROD_W'(p_q[i]) * PROD_W'(coef(i));
      end
   end

   // Stage 3: sum the eight products at full accumulator width.
   always_comb begin
      s_d = '0;
      for (int i = 0; i < HALF; i++) begin
         s_d = s_d + ACC_W'(m_q[i]);
      end
   end

   // Stage 4: round half up, then saturate or wrap into the output width.
   always_comb begin
      rounded = s_q + ROUND_HALF;
      r       = rounded >>> FRAC_W;
`ifdef FIR_SAT_EN
      if (r > ACC_W'(32'sd32767)) begin
         y_d = sample_t'(16'sh7fff);
      end else if (r < ACC_W'(-32'sd32768)) begin
         y_d = sample_t'(16'sh8000);
      end else begin
         y_d = r[DATA_W-1:0];
      end
`else
      y_d = r[DATA_W-1:0];
`endif
   end

`ifndef FIR_SAT_EN
   // In wrap mode the bits above the output width are dropped on purpose.
   logic r_hi_unused;
   assign r_hi_unused = ^r[ACC_W-1:DATA_W];
`endif

   // Register every stage. A synchronous reset flushes all history.
   // NOTE: sequential state is written only with non-blocking assignments,
   // so every stage samples the values the previous stage held before this
   // edge.
   // NOTE: the delay line is an array, but it is still reset. A reset must
   // clear the filter history so that the output restarts from a zero past.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NTAPS; i++) begin
            x_q[i] <= '0;
         end
         for (int i = 0; i < HALF; i++) begin
            p_q[i] <= '0;
            m_q[i] <= '0;
         end
         s_q <= '0;
         y_q <= '0;
      end else begin
         for (int i = 0; i < NTAPS; i++) begin
            x_q[i] <= x_d[i];
         end
         for (int i = 0; i < HALF; i++) begin
            p_q[i] <= p_d[i];
            m_q[i] <= m_d[i];
         end
         s_q <= s_d;
         y_q <= y_d;
      end
   end

   assign data_out = y_q;

endmodule

// File: tb/tb_fir_lowpass_16tap.sv
// ----------------------------------------------------------------------------
// tb_fir_lowpass_16tap
//   Self-checking bench for fir_lowpass_16tap.
//   The reference model is a plain direct-form convolution over a history
//   array. Its output passes through a 4-deep delay and is compared with the
//   DUT every clock. Directed checks cover:
//     - reset
//     - impulse response
//     - DC steps to +full scale and -full scale
//     - output overflow
//     - a two-tone mix
//     - a reset in the middle of the stream
//   Randomized samples, with occasional resets, finish the run.
//   Build FIR_SAT_EN into both DUT and bench to select saturating outputs.
// ----------------------------------------------------------------------------
module tb_fir_lowpass_16tap;

   logic               clk;
   logic               rst;
   logic signed [15:0] data_in;
   logic signed [15:0] data_out;

   int n_checks = 0;
   int n_fail   = 0;

   fir_lowpass_16tap dut (
      .clk      (clk),
      .rst      (rst),
      .data_in  (data_in),
      .data_out (data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference state: full 16-tap impulse response, sample history, and a
   // 5-slot output delay. out_dly[4] is the value due after the current edge.
   int     h_full  [16];
   longint hist    [16];
   longint out_dly [5];

   localparam real PI = 3.14159265358979;

`ifdef FIR_SAT_EN
   localparam longint SAT_EXP = 32767;
`else
   localparam longint SAT_EXP = -30841;
`endif

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Direct-form y = sum h[j]*x[n-j], rounded half up, then clipped or wrapped.
   function automatic longint ref_y();
      longint acc = 0;
      longint r;
      for (int j = 0; j < 16; j++) begin
         acc += longint'(h_full[j]) * hist[j];
      end
      r = (acc + 16384) >>> 15;
`ifdef FIR_SAT_EN
      if (r > 32767)  r = 32767;
      if (r < -32768) r = -32768;
`else
      r = longint'(shortint'(r));
`endif
      return r;
   endfunction

   // Run one clock: drive the inputs, update the model at the edge, then
   // compare the DUT with the model shortly after the edge.
   task automatic step(input logic r_in, input int din, output longint y);
      @(negedge clk);
      rst     = r_in;
      data_in = 16'(din);
      @(posedge clk);
      if (r_in) begin
         for (int j = 0; j < 16; j++) hist[j] = 0;
         for (int j = 0; j < 5; j++)  out_dly[j] = 0;
      end else begin
         for (int j = 15; j > 0; j--) hist[j] = hist[j-1];
         hist[0] = longint'(din);
         for (int j = 4; j > 0; j--) out_dly[j] = out_dly[j-1];
         out_dly[0] = ref_y();
      end
      #1;
      y = longint'(data_out);
      check("stream", y, out_dly[4]);
   endtask

   function automatic int tone(input int n);
      real v;
      v = 8192.0 * $sin(2.0 * PI * 0.02 * n) + 8192.0 * $sin(2.0 * PI * 0.3 * n);
      return int'(v);
   endfunction

   // Hard stop if the run ever stalls.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int     half_h [8];
      int     imp    [16];
      int     sat_pat [16];
      longint y;
      real    s2, c2, s30, c30, a2, a30;

      half_h = '{-92, -210, -180, 360, 1480, 3400, 5200, 6426};
      for (int i = 0; i < 8; i++) begin
         h_full[i]    = half_h[i];
         h_full[15-i] = half_h[i];
      end
      imp = '{-46, -105, -90, 180, 740, 1700, 2600, 3213,
              3213, 2600, 1700, 740, 180, -90, -105, -46};
      for (int j = 0; j < 16; j++)  hist[j] = 0;
      for (int j = 0; j < 5; j++)   out_dly[j] = 0;

      rst     = 1'b1;
      data_in = '0;

      // Reset held with a non-zero input, then release with zeros.
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1234, y);
         check("reset_hold", y, 0);
      end
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 0, y);
         check("reset_release", y, 0);
      end

      // Impulse response.
      step(1'b0, 16384, y);
      for (int n = 1; n <= 21; n++) begin
         step(1'b0, 0, y);
         check("impulse", y, (n >= 4 && n < 20) ? longint'(imp[n-4]) : 0);
      end

      // DC steps to both full-scale extremes.
      for (int n = 0; n < 30; n++) begin
         step(1'b0, 32767, y);
         if (n >= 19) check("dc_pos", y, 32767);
      end
      for (int n = 0; n < 30; n++) begin
         step(1'b0, -32768, y);
         if (n >= 19) check("dc_neg", y, -32768);
      end

      // Output overflow: after 16 samples, taps 0-2 and 13-15 hold -32768
      // and taps 3-12 hold +32767. The oldest sample (tap 15) goes in first.
      for (int j = 0; j < 16; j++) begin
         sat_pat[j] = (j <= 2 || j >= 13) ? -32768 : 32767;
      end
      for (int i = 0; i < 16; i++) step(1'b0, sat_pat[15-i], y);
      for (int i = 0; i < 4; i++)  step(1'b0, 0, y);
      check("saturation", y, SAT_EXP);

      // Two-tone mix: measure 2 MHz and 30 MHz content over 100 settled samples.
      s2 = 0.0; c2 = 0.0; s30 = 0.0; c30 = 0.0;
      for (int n = 0; n < 200; n++) begin
         step(1'b0, tone(n), y);
         if (n >= 100) begin
            s2  += real'(y) * $sin(2.0 * PI * 0.02 * n);
            c2  += real'(y) * $cos(2.0 * PI * 0.02 * n);
            s30 += real'(y) * $sin(2.0 * PI * 0.3 * n);
            c30 += real'(y) * $cos(2.0 * PI * 0.3 * n);
         end
      end
      a2  = 0.02 * $sqrt(s2 * s2 + c2 * c2);
      a30 = 0.02 * $sqrt(s30 * s30 + c30 * c30);
      check("tone_pass_band", (a2 > 6000.0) ? 1 : 0, 1);
      check("tone_residue",   (a30 * 10.0 < a2) ? 1 : 0, 1);

      // One-clock reset in the middle of the tone, then an impulse from zero.
      step(1'b1, tone(200), y);
      check("midstream_reset", y, 0);
      step(1'b0, 16384, y);
      for (int n = 1; n <= 21; n++) begin
         step(1'b0, 0, y);
         check("impulse_after_rst", y, (n >= 4 && n < 20) ? longint'(imp[n-4]) : 0);
      end

      // Randomized samples, biased toward the extremes, with occasional resets.
      for (int n = 0; n < 400; n++) begin
         int sel;
         int din;
         sel = int'($urandom_range(0, 9));
         if (sel < 2)      din = -32768;
         else if (sel < 4) din = 32767;
         else              din = int'($urandom_range(0, 65535)) - 32768;
         step(($urandom_range(0, 49) == 0), din, y);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
